timer_counter: RTL and testbench

- Memory-mapped programmable countdown timer on the Cpu's bridge port.
- Consumes the Cpu's bus outputs: address, store data and write enable.
- Returns read data through the bridge read mux.
- Its interrupt output drives hwInt_Outside[0] of the Cpu.
- Two modes: one-shot (mode 0) and auto-reload periodic (mode 1).

---
 rtl/timer_counter_if.sv | 25 ++
 rtl/timer_counter.sv | 127 ++++++++++++
 tb/tb_timer_counter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// Bridge-side bus bundle between the CPU and the memory-mapped timer:
// address, store data and strobe in; read data and interrupt out.
interface timer_counter_if;
  logic [31:0] addr_Bridge;
  logic [31:0] dOut_Bridge;
  logic        ifWr_Bridge;
  logic [31:0] dIn_Bridge;
  logic        irq;

  modport master (
    output addr_Bridge,
    output dOut_Bridge,
    output ifWr_Bridge,
    input  dIn_Bridge,
    input  irq
  );

  modport slave (
    input  addr_Bridge,
    input  dOut_Bridge,
    input  ifWr_Bridge,
    output dIn_Bridge,
    output irq
  );
endinterface

// File: rtl/timer_counter.sv
// Programmable countdown timer on the CPU bridge: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload periodic mode, maskable level interrupt.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          CNT_WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [31:0]          END_ADDR   = BASE_ADDR + 32'hB;
  localparam logic [1:0]           REG_CTRL   = 2'd0;
  localparam logic [1:0]           REG_PRESET = 2'd1;
  localparam logic [1:0]           REG_COUNT  = 2'd2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  state_t               state_q;
  logic [3:0]           ctrl_q;
  logic [CNT_WIDTH-1:0] preset_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 irq_flag_q;

  logic       sel;
  logic [1:0] idx;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       ctrl_en;
  logic       ctrl_periodic;
  logic       ctrl_im;
  logic       last_tick;

  // Unsigned saturating decrement: COUNT never wraps below zero.
  function automatic logic [CNT_WIDTH-1:0] sat_dec(input logic [CNT_WIDTH-1:0] v);
    return (v > CNT_ONE) ? (v - CNT_ONE) : '0;
  endfunction

  assign sel       = (bus.addr_Bridge >= BASE_ADDR) && (bus.addr_Bridge <= END_ADDR);
  assign idx       = bus.addr_Bridge[3:2];
  assign wr_ctrl   = bus.ifWr_Bridge && sel && (idx == REG_CTRL);
  assign wr_preset = bus.ifWr_Bridge && sel && (idx == REG_PRESET);

  assign ctrl_en       = ctrl_q[0];
  assign ctrl_periodic = (ctrl_q[2:1] == 2'b01);
  assign ctrl_im       = ctrl_q[3];

  // COUNT<=1 is the terminal step, so PRESET=0 times out like PRESET=1.
  assign last_tick = (count_q <= CNT_ONE);
  assign count_d   = sat_dec(count_q);

  always_comb begin
    bus.dIn_Bridge = 32'h0;
    if (sel) begin
      unique case (idx)
        REG_CTRL:   bus.dIn_Bridge = {28'h0, ctrl_q};
        REG_PRESET: bus.dIn_Bridge = 32'(preset_q);
        REG_COUNT:  bus.dIn_Bridge = 32'(count_q);
        default:    bus.dIn_Bridge = 32'h0;
      endcase
    end
  end

  assign bus.irq = ctrl_im & irq_flag_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 4'h0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      if (wr_preset) begin
        preset_q <= bus.dOut_Bridge[CNT_WIDTH-1:0];
      end

      unique case (state_q)
        S_IDLE: begin
          if (ctrl_en) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          count_q    <= preset_q;
          irq_flag_q <= 1'b0;
          state_q    <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl_en) begin
            state_q <= S_IDLE;
          end else if (!last_tick) begin
            count_q <= count_d;
          end else begin
            count_q    <= '0;
            irq_flag_q <= 1'b1;
            state_q    <= S_INT;
          end
        end
        S_INT: begin
          if (ctrl_periodic) begin
            irq_flag_q <= 1'b0;
            state_q    <= S_LOAD;
          end else begin
            ctrl_q[0] <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Placed last so a bus CTRL write overrides the FSM's EN clear and flag set.
      if (wr_ctrl) begin
        ctrl_q     <= bus.dOut_Bridge[3:0];
        irq_flag_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register/decode vector table plus
// hand-timed sequences for one-shot, periodic, mask, disable and reset cases.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_IDLE   = 32'h0000_0000;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  timer_counter_if bif ();

  timer_counter #(
    .BASE_ADDR (BASE),
    .CNT_WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bif.addr_Bridge = a;
    #1;
    d = bif.dIn_Bridge;
    bif.addr_Bridge = A_IDLE;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bif.addr_Bridge = a;
    bif.dOut_Bridge = d;
    bif.ifWr_Bridge = 1'b1;
    tick();
    bif.ifWr_Bridge = 1'b0;
    bif.addr_Bridge = A_IDLE;
    bif.dOut_Bridge = 32'h0;
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic chk_irq(input string nm, input logic exp);
    chk(nm, {31'h0, bif.irq}, {31'h0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int pulses;
    checks   = 0;
    failures = 0;
    bif.addr_Bridge = A_IDLE;
    bif.dOut_Bridge = 32'h0;
    bif.ifWr_Bridge = 1'b0;

    // Register / decode vectors (timer disabled throughout).
    vt[0] = '{1'b1, A_PRESET,          32'h1234_5678, A_PRESET,          32'h1234_5678};
    vt[1] = '{1'b1, A_CTRL,            32'hFFFF_FFF6, A_CTRL,            32'h0000_0006};
    vt[2] = '{1'b1, BASE + 32'hC,      32'h0000_AAAA, A_PRESET,          32'h1234_5678};
    vt[3] = '{1'b1, BASE - 32'h4,      32'h0000_0005, A_CTRL,            32'h0000_0006};
    vt[4] = '{1'b1, BASE - 32'hC,      32'h0000_0077, A_PRESET,          32'h1234_5678};
    vt[5] = '{1'b1, A_COUNT,           32'h0000_0077, A_COUNT,           32'h0000_0000};
    vt[6] = '{1'b0, A_IDLE,            32'h0,         BASE + 32'hC,      32'h0000_0000};
    vt[7] = '{1'b0, A_IDLE,            32'h0,         BASE + 32'h14,     32'h0000_0000};
    vt[8] = '{1'b0, A_IDLE,            32'h0,         BASE - 32'hC,      32'h0000_0000};
    vt[9] = '{1'b1, A_CTRL,            32'h0000_0000, A_CTRL,            32'h0000_0000};

    // Reset: held low two cycles, writes during reset are discarded.
    reset = 1'b0;
    tick();
    tick();
    chk_rd("rst_ctrl", A_CTRL, 32'h0);
    chk_rd("rst_preset", A_PRESET, 32'h0);
    chk_rd("rst_count", A_COUNT, 32'h0);
    chk_irq("rst_irq", 1'b0);
    wr(A_CTRL, 32'h0000_000F);
    wr(A_PRESET, 32'h0000_0042);
    reset = 1'b1;
    tick();
    chk_rd("rst_ctrl_after", A_CTRL, 32'h0);
    chk_rd("rst_preset_after", A_PRESET, 32'h0);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].we) wr(vt[i].waddr, vt[i].wdata);
      else tick();
      chk_rd($sformatf("vec%0d_rd", i), vt[i].raddr, vt[i].exp_rd);
      chk_irq($sformatf("vec%0d_irq", i), 1'b0);
    end

    // One-shot, PRESET=3: COUNT 3,2,1,0 then irq held; EN self-clears.
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);
    begin
      logic [31:0] exp_cnt [5];
      logic        exp_irq [5];
      exp_cnt = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
      exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
        tick();
        chk_rd($sformatf("os_count_e%0d", k + 1), A_COUNT, exp_cnt[k]);
        chk_irq($sformatf("os_irq_e%0d", k + 1), exp_irq[k]);
      end
    end
    tick();
    chk_rd("os_ctrl_after", A_CTRL, 32'h8);
    tick();
    tick();
    chk_irq("os_irq_held", 1'b1);
    wr(A_CTRL, 32'h0);
    chk_irq("os_irq_cleared", 1'b0);

    // Periodic, PRESET=2: 1-cycle pulse on every 4th edge.
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    pulses = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk_irq($sformatf("per_irq_e%0d", k), (k % 4) == 0);
      if (bif.irq) pulses++;
    end
    chk("per_pulses", pulses, 3);
    chk_rd("per_ctrl", A_CTRL, 32'hB);
    wr(A_CTRL, 32'h0);

    // Mask: flag sets but IM=0 hides it; CTRL write clears the flag.
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bif.irq) pulses++;
    end
    chk("mask_irq_seen", pulses, 0);
    chk_rd("mask_ctrl_en_cleared", A_CTRL, 32'h0);
    wr(A_CTRL, 32'h8);
    chk_irq("mask_im_set_irq", 1'b0);
    tick();
    tick();
    chk_irq("mask_im_set_irq_later", 1'b0);
    wr(A_CTRL, 32'h0);

    // CTRL write landing on the INT edge: bus keeps EN, flag cleared, restarts.
    wr(A_CTRL, 32'h9);
    tick();
    tick();
    tick();
    chk_irq("race_irq_int", 1'b1);
    wr(A_CTRL, 32'h9);
    chk_rd("race_ctrl", A_CTRL, 32'h9);
    chk_irq("race_irq_cleared", 1'b0);
    tick();
    tick();
    tick();
    chk_irq("race_irq_again", 1'b1);
    wr(A_CTRL, 32'h0);

    // Disable mid-count at COUNT=6: freezes at 5, reload on re-enable.
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 6; k++) tick();
    chk_rd("dis_count_before", A_COUNT, 32'd6);
    wr(A_CTRL, 32'h8);
    chk_rd("dis_count_edge", A_COUNT, 32'd5);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bif.irq) pulses++;
    end
    chk_rd("dis_count_frozen", A_COUNT, 32'd5);
    chk("dis_irq_seen", pulses, 0);
    wr(A_CTRL, 32'h1);
    tick();
    tick();
    chk_rd("dis_reload", A_COUNT, 32'd10);
    wr(A_PRESET, 32'd3);
    chk_rd("dis_preset_no_effect", A_COUNT, 32'd9);
    wr(A_CTRL, 32'h0);

    // Reset pulse mid-count in periodic mode at COUNT=4.
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'hB);
    tick();
    tick();
    tick();
    chk_rd("rmid_count_before", A_COUNT, 32'd4);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_rd("rmid_ctrl", A_CTRL, 32'h0);
    chk_rd("rmid_preset", A_PRESET, 32'h0);
    chk_rd("rmid_count", A_COUNT, 32'h0);
    chk_irq("rmid_irq", 1'b0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bif.irq) pulses++;
    end
    chk("rmid_no_pulses", pulses, 0);
    rd(A_COUNT, d);
    chk("rmid_count_still0", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
